// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential 32x32 multiply / divide unit with HI/LO registers.
// One operation takes a fixed 33 cycles from accept to result: 32 iterative
// shift-add or restoring shift-subtract steps on unsigned magnitudes, then a
// FIX cycle that applies sign correction and writes HI/LO.
//
// Request semantics: start and mt_we are sampled only while the unit is idle.
// While busy they are ignored, and stall tells the requester to hold them.
// mf_req never changes state; it only raises stall while busy.
module muldiv_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic        mt_we,
    input  logic        mt_sel,
    input  logic        mf_req,
    input  logic        mf_sel,
    output logic [31:0] mf_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic        divzero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    // Iteration counter and shared accumulator.
    // MUL: acc = {partial product high, multiplier shifting out}.
    // DIV: acc = {partial remainder, dividend shifting out / quotient in}.
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opnd;       // multiplicand (MUL) or divisor (DIV) magnitude
    logic        is_div;
    logic        sign_a;     // dividend / multiplicand was negative (signed ops)
    logic        sign_b;     // divisor / multiplier was negative (signed ops)
    logic        b_zero;

    logic        accept;
    logic        mt_write;

    logic        a_neg_in;
    logic        b_neg_in;
    logic [31:0] a_mag_in;
    logic [31:0] b_mag_in;

    logic [32:0] mul_sum;
    logic [32:0] div_diff;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // Operand magnitudes; op[0] selects the signed variants.
    always_comb begin
        a_neg_in = op[0] & srca[31];
        b_neg_in = op[0] & srcb[31];
        a_mag_in = a_neg_in ? (~srca + 32'd1) : srca;
        b_mag_in = b_neg_in ? (~srcb + 32'd1) : srcb;
    end

    // Single iteration step for each operation plus the final sign fix-up.
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + {1'b0, opnd};
        div_diff = acc[63:31] - {1'b0, opnd};
        prod_fix = (sign_a ^ sign_b) ? (~acc + 64'd1) : acc;
        quo_fix  = (sign_a ^ sign_b) ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem_fix  = sign_a ? (~acc[63:32] + 32'd1) : acc[63:32];
        // A zero divisor leaves the dividend as remainder, which the sign
        // fix turns back into srca; only the quotient needs forcing.
        res_hi   = is_div ? rem_fix : prod_fix[63:32];
        res_lo   = is_div ? (b_zero ? 32'hFFFF_FFFF : quo_fix) : prod_fix[31:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and request decode; start wins over mt_we in IDLE.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        mt_write   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = op[1] ? DIV : MUL;
                end else if (mt_we) begin
                    mt_write = 1'b1;
                end
            end
            MUL: begin
                if (cnt == 5'd31) state_next = FIX;
            end
            DIV: begin
                if (cnt == 5'd31) state_next = FIX;
            end
            FIX: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath, HI/LO and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= 5'd0;
            acc     <= 64'd0;
            opnd    <= 32'd0;
            is_div  <= 1'b0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            b_zero  <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            divzero <= 1'b0;
        end else begin
            done    <= 1'b0;
            divzero <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt    <= 5'd0;
                        busy   <= 1'b1;
                        is_div <= op[1];
                        sign_a <= a_neg_in;
                        sign_b <= b_neg_in;
                        b_zero <= (srcb == 32'd0);
                        if (op[1]) begin
                            acc  <= {32'd0, a_mag_in};
                            opnd <= b_mag_in;
                        end else begin
                            acc  <= {32'd0, b_mag_in};
                            opnd <= a_mag_in;
                        end
                    end else if (mt_write) begin
                        if (mt_sel) hi <= srca;
                        else        lo <= srca;
                    end
                end
                MUL: begin
                    if (acc[0]) acc <= {mul_sum, acc[31:1]};
                    else        acc <= {1'b0, acc[63:1]};
                    cnt <= cnt + 5'd1;
                end
                DIV: begin
                    if (!div_diff[32]) acc <= {div_diff[31:0], acc[30:0], 1'b1};
                    else               acc <= {acc[62:0], 1'b0};
                    cnt <= cnt + 5'd1;
                end
                FIX: begin
                    hi      <= res_hi;
                    lo      <= res_lo;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    divzero <= is_div & b_zero;
                end
                default: ;
            endcase
        end
    end

    assign mf_data = mf_sel ? hi : lo;
    assign stall   = busy & (start | mf_req | mt_we);

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq. Stimulus tasks push the expected
// {divzero, hi, lo} and completion cycle; a negedge monitor pops and compares
// whenever done is high.
module tb_muldiv_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        mt_we;
    logic        mt_sel;
    logic        mf_req;
    logic        mf_sel;
    logic [31:0] mf_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;
    logic        divzero;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    logic [64:0] exp_q[$];
    int          cyc_q[$];
    int          cyc;
    int          n_checks;
    int          n_pass;

    muldiv_seq dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .srca    (srca),
        .srcb    (srcb),
        .mt_we   (mt_we),
        .mt_sel  (mt_sel),
        .mf_req  (mf_req),
        .mf_sel  (mf_sel),
        .mf_data (mf_data),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .divzero (divzero)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                logic [64:0] e;
                int          ec;
                e  = exp_q.pop_front();
                ec = cyc_q.pop_front();
                check("result_hi", 64'(hi), 64'(e[63:32]));
                check("result_lo", 64'(lo), 64'(e[31:0]));
                check("result_divzero", 64'(divzero), 64'(e[64]));
                check("done_latency", 64'(cyc), 64'(ec));
            end
        end
    end

    // Drive a start at the current negedge; return at the next negedge.
    task automatic op_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eh, input logic [31:0] el, input logic edz,
                            input logic push);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        old_hi = hi;
        old_lo = lo;
        start  = 1'b1;
        op     = o;
        srca   = a;
        srcb   = b;
        mf_req = 1'b1;
        mf_sel = 1'b0;
        if (push) begin
            exp_q.push_back({edz, eh, el});
            cyc_q.push_back(cyc + 34);
        end
        #1;
        check("mf_old_value", 64'(mf_data), 64'(old_lo));
        check("idle_no_stall", 64'(stall), 64'd0);
        @(negedge clk);
        start  = 1'b0;
        mt_we  = 1'b0;
        mf_req = 1'b0;
        check("accept_busy", 64'(busy), 64'd1);
        check("accept_hi_hold", 64'(hi), 64'(old_hi));
        check("accept_lo_hold", 64'(lo), 64'(old_lo));
    endtask

    // Count further busy cycles; returns at the negedge where busy has dropped.
    task automatic op_wait(output int n);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    task automatic check_read(input logic [31:0] eh, input logic [31:0] el);
        mf_req = 1'b1;
        mf_sel = 1'b1;
        #1;
        check("mf_read_hi", 64'(mf_data), 64'(eh));
        mf_sel = 1'b0;
        #1;
        check("mf_read_lo", 64'(mf_data), 64'(el));
        check("mf_idle_stall", 64'(stall), 64'd0);
        mf_req = 1'b0;
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic edz);
        int n;
        op_start(o, a, b, eh, el, edz, 1'b1);
        op_wait(n);
        check("busy_cycles", 64'(n + 1), 64'd33);
        check_read(eh, el);
    endtask

    initial begin
        int n;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        n_checks = 0;
        n_pass   = 0;
        reset  = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        srca   = 32'd0;
        srcb   = 32'd0;
        mt_we  = 1'b0;
        mt_sel = 1'b0;
        mf_req = 1'b0;
        mf_sel = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_divzero", 64'(divzero), 64'd0);

        // Move-to HI, then LO.
        mt_we = 1'b1; mt_sel = 1'b1; srca = 32'h1234;
        @(negedge clk);
        mt_we = 1'b0;
        check("mt_hi", 64'(hi), 64'h1234);
        check("mt_hi_lo_hold", 64'(lo), 64'd0);
        mt_we = 1'b1; mt_sel = 1'b0; srca = 32'h55AA;
        @(negedge clk);
        mt_we = 1'b0;
        check("mt_lo", 64'(lo), 64'h55AA);
        check("mt_lo_hi_hold", 64'(hi), 64'h1234);
        check_read(32'h1234, 32'h55AA);

        // Arithmetic vectors, issued back to back in each done cycle.
        do_op(OP_MULTU, 32'd7,          32'd6,          32'h0000_0000, 32'd42,        1'b0);
        do_op(OP_MULT,  32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        do_op(OP_DIV,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        do_op(OP_DIVU,  32'd100,        32'd0,          32'd100,       32'hFFFF_FFFF, 1'b1);
        do_op(OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 1'b0);
        do_op(OP_DIV,   32'hFFFF_FF9C,  32'd0,          32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b1);
        do_op(OP_MULT,  32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000, 1'b0);
        do_op(OP_DIVU,  32'hFFFF_FFFF,  32'd10,         32'd5,         32'h1999_9999, 1'b0);

        // start and mt_we together in IDLE: the move-to is discarded.
        mt_we = 1'b1; mt_sel = 1'b1;
        do_op(OP_MULTU, 32'd3,          32'd3,          32'd0,         32'd9,         1'b0);

        // Requests while busy stall and are ignored.
        op_start(OP_MULTU, 32'h0001_0000, 32'h0001_0003, 32'h1, 32'h0003_0000, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        old_hi = hi;
        old_lo = lo;
        start = 1'b1; op = OP_DIVU; srca = 32'd5; srcb = 32'd1;
        mf_req = 1'b1; mf_sel = 1'b0; mt_we = 1'b1; mt_sel = 1'b1;
        #1;
        check("busy_stall", 64'(stall), 64'd1);
        check("busy_mf_old", 64'(mf_data), 64'(old_lo));
        repeat (3) @(negedge clk);
        check("busy_hi_hold", 64'(hi), 64'(old_hi));
        check("busy_lo_hold", 64'(lo), 64'(old_lo));
        check("busy_stall_held", 64'(stall), 64'd1);
        start = 1'b0; mf_req = 1'b0; mt_we = 1'b0;
        #1;
        check("busy_no_req_stall", 64'(stall), 64'd0);
        op_wait(n);
        check("stall_busy_cycles", 64'(n + 8), 64'd33);
        check_read(32'h1, 32'h0003_0000);

        // Reset in the middle of a divide: no result, no done.
        start = 1'b1; op = OP_DIVU; srca = 32'd1000; srcb = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_divzero", 64'(divzero), 64'd0);
        do_op(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 The ports SHALL be as follows (name  direction  width  meaning):
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  issue request for a multiply/divide operation.
- op  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- srca  in  32  multiplicand / dividend; also the move-to data.
- srcb  in  32  multiplier / divisor.
- mt_we  in  1  write srca into HI or LO.
- mt_sel  in  1  move-to target: 0 = LO, 1 = HI.
- mf_req  in  1  read request for HI/LO.
- mf_sel  in  1  move-from source: 0 = LO, 1 = HI.
- mf_data  out  32  combinational read data: mf_sel ? hi : lo.
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  registered; high while an operation is in flight.
- stall  out  1  combinational; high when the pipeline must hold.
- done  out  1  registered; one-cycle completion pulse.
- divzero  out  1  registered; pulses together with done on divide-by-zero.

Function
REQ-003 The state machine SHALL have the states IDLE, MUL, DIV and FIX.
REQ-004 In IDLE, start=1 SHALL be accepted on that rising edge (E0).
- Acceptance latches srca, srcb and op.
- MULT and DIV latch operand magnitudes plus sign bits.
- The next state is MUL (op[1]=0) or DIV (op[1]=1).
- A 5-bit iteration counter is cleared.
REQ-005 MUL SHALL perform one unsigned shift-add step per cycle over 32 cycles (edges E1..E32), accumulating a 64-bit product, then go to FIX.
REQ-006 DIV SHALL perform one unsigned restoring shift-subtract step per cycle over 32 cycles (edges E1..E32), producing a 32-bit quotient and remainder, then go to FIX.
REQ-007 On edge E33, FIX SHALL apply sign correction, write hi/lo, and return to IDLE.
- MULT: negate the 64-bit product if the operand signs differ.
- DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
- Writes: hi = product[63:32] or remainder; lo = product[31:0] or quotient.
REQ-008 busy SHALL be 1 in the cycles after E0 through E33, and 0 in the cycle after E33.
REQ-009 done SHALL be 1 for exactly the cycle following E33; hi/lo are already valid in that cycle.
REQ-010 Fixed latency SHALL be 33 cycles from accept to result, independent of operand values.
REQ-011 Divide-by-zero (srcb=0, DIVU or DIV) SHALL still take 33 cycles, and SHALL produce:
- lo = 32'hFFFFFFFF;
- hi = srca;
- divzero pulsed with done.
REQ-012 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give lo = 32'h80000000 and hi = 0.
REQ-013 stall SHALL equal busy & (start | mf_req | mt_we).
REQ-014 While busy, start and mt_we SHALL be ignored (no state change), and the requester holds the request until stall falls.
REQ-015 In IDLE, mt_we=1 SHALL write srca to LO (mt_sel=0) or HI (mt_sel=1) on that edge.
REQ-016 If start and mt_we are both 1 in IDLE, start SHALL win and mt_we SHALL be discarded.
REQ-017 mf_req in IDLE SHALL return the current hi/lo value with no stall, including in the same cycle a start is accepted (old value returned).
REQ-018 During the done cycle the block SHALL be in IDLE: a new start is accepted, and mf_data returns the new result.
REQ-019 hi and lo SHALL change only at E33, on an mt_we write, or on reset.
- Intermediate accumulators are internal.
- hi and lo hold their values across a busy period.

Reset
REQ-020 reset=1 at a rising edge SHALL force state IDLE and clear hi, lo, busy, done, divzero and the counter to 0, overriding all other inputs.
REQ-021 reset asserted mid-operation SHALL abort the operation with no result write, and done SHALL not pulse.
REQ-022 After reset deasserts, start SHALL be accepted on the first edge.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- MULTU 7 x 6 -> hi=0, lo=42; done exactly 33 cycles after accept; busy high 33 cycles.
- MULT 32'hFFFFFFFD x 5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1.
- DIV 32'hFFFFFFF9 / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- DIVU 100 / 0 -> lo=32'hFFFFFFFF, hi=100; divzero=1 with done.
- DIV 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- MULTU then start and mf_req at cycle 5 -> stall=1; second start ignored; hi/lo unchanged until E33.
- mt_we=1, mt_sel=1, srca=32'h1234 in IDLE -> hi=32'h1234 next cycle; lo unchanged.
- reset at iteration 10 of DIVU -> hi=lo=0, busy=0, no done; new start accepted on the next edge.
